retire_uov_gen: RTL

RETIRE_UOV_GEN -- requirements
Module: retire_uov_gen

---
 rtl/nou_retire_pkg.sv | 30 +++
 rtl/nou_mask_fifo.sv | 63 ++++++
 rtl/retire_uov_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nou_retire_pkg.sv
// Shared sizing constants and mask type for the retire / unit-output-vector generator.
// No logic; constants only.
// No flow control.
`ifndef NOU_UOV_SIZE
`define NOU_UOV_SIZE 4
`endif

package nou_retire_pkg;

    // One bit per functional unit.
    localparam int UOV_SIZE_DEF = `NOU_UOV_SIZE;

    // Maximum number of issued entries awaiting retirement (power of two, >= 2).
    localparam int DEPTH_DEF = 4;

    // Pointer width indexes the storage; the count needs one extra bit to represent "full".
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    typedef logic [UOV_SIZE_DEF-1:0] uov_mask_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nou_mask_fifo.sv
// Circular store of issued unit masks; head entry is always visible combinationally.
// Latency: a pushed mask becomes the head no earlier than the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; the owner checks full/empty.
module nou_mask_fifo
    import nou_retire_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = UOV_SIZE_DEF,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_mask,
    input  logic             pop,
    output logic [WIDTH-1:0] head_mask,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_mask = mem[rd_ptr];

    // Storage is qualified by the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_mask;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/retire_uov_gen.sv
// Tracks issued entries' unit masks, retires the head in order once all its units report done.
// Latency: final unit_done of the head in cycle t -> retire_vld/unit_output_vector in t+1.
// Backpressure: issue_ready low while DEPTH entries are held; an issue then is dropped and flagged.
`ifndef NOU_UOV_SIZE
`define NOU_UOV_SIZE 4
`endif

module retire_uov_gen
    import nou_retire_pkg::*;
#(
    parameter int UOV_SIZE = `NOU_UOV_SIZE,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                issue_vld,
    input  logic [UOV_SIZE-1:0] issue_unit_mask,
    output logic                issue_ready,
    input  logic [UOV_SIZE-1:0] unit_done,
    output logic [UOV_SIZE-1:0] unit_output_vector,
    output logic                retire_vld,
    output logic [CNT_W-1:0]    outstanding_cnt,
    output logic                protocol_err
);

    logic [UOV_SIZE-1:0] head_mask;
    logic [UOV_SIZE-1:0] done_reg;
    logic [UOV_SIZE-1:0] outstanding_units;
    logic [UOV_SIZE-1:0] done_eff;
    logic [UOV_SIZE-1:0] clr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                retire;
    logic                err_set;

    nou_mask_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UOV_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_mask (issue_unit_mask),
        .pop       (retire),
        .head_mask (head_mask),
        .count     (outstanding_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready reflects registered occupancy only, so a same-cycle retire never opens a slot early.
    assign issue_ready = ~fifo_full;
    assign push        = issue_vld & issue_ready;

    // Head retires when every unit it claimed has completed, counting this cycle's pulses;
    // an entry pushed this cycle is not yet visible as head because occupancy is registered.
    always_comb begin
        done_eff = done_reg | unit_done;
        retire   = 1'b0;
        clr      = '0;
        if (!fifo_empty && ((head_mask & ~done_eff) == '0)) begin
            retire = 1'b1;
            clr    = head_mask;
        end
    end

    // Protocol violations: completion from an idle unit, re-claiming a busy unit, issuing while full.
    always_comb begin
        err_set = 1'b0;
        if ((unit_done & ~outstanding_units) != '0) begin
            err_set = 1'b1;
        end
        if (push && ((issue_unit_mask & outstanding_units) != '0)) begin
            err_set = 1'b1;
        end
        if (issue_vld && !issue_ready) begin
            err_set = 1'b1;
        end
    end

    // Completion accumulator; the retiring entry's bits are consumed as it leaves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_reg <= '0;
        end else begin
            done_reg <= done_eff & ~clr;
        end
    end

    // Union of all held masks: set on accepted issue, released by the retiring head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_units <= '0;
        end else begin
            outstanding_units <= (outstanding_units & ~clr) | (push ? issue_unit_mask : '0);
        end
    end

    // One-cycle retire pulse carrying the released units to decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_vld         <= 1'b0;
            unit_output_vector <= '0;
        end else begin
            retire_vld         <= retire;
            unit_output_vector <= clr;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            protocol_err <= 1'b0;
        end else if (err_set) begin
            protocol_err <= 1'b1;
        end
    end

endmodule
